// File: rtl/adder_pkg.sv
// Shared types for the bit-serial adder and its operand feeder.
package adder_pkg;
  localparam int W     = 8;
  localparam int FRAME = W + 1;

  typedef logic [W-1:0]            operand_t;
  typedef logic [W:0]              sum_t;
  typedef logic [$clog2(W+1)-1:0]  frame_cnt_t;

  typedef struct packed {
    operand_t m;
    operand_t n;
  } pair_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, any DEPTH >= 1, element type T, with occupancy count.
module sync_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [7:0],
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
)(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  T              data_i,
  output T              data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full_o  = (count_o == CW'(DEPTH));
  assign empty_o = (count_o == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full queue is fine when the head leaves on the same edge.
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= inc(rd_ptr);
      if (do_push & ~do_pop)      count_o <= count_o + CW'(1);
      else if (do_pop & ~do_push) count_o <= count_o - CW'(1);
    end
  end
endmodule

// File: rtl/adder_operand_feeder.sv
// Valid/ready wrapper around the free-running bit-serial adder: feeds one operand
// pair per W+1-cycle frame and collects each W+1-bit sum in order.
module adder_operand_feeder
  import adder_pkg::*;
#(
  parameter int W         = adder_pkg::W,
  parameter int INQ_DEPTH = 2,
  parameter int RES_DEPTH = 4,
  parameter int PHASE0    = 0
)(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_m_i,
  input  logic [W-1:0] in_n_i,
  output logic [W-1:0] add_m_o,
  output logic [W-1:0] add_n_o,
  input  logic [W:0]   add_sum_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [W:0]   res_sum_o,
  output logic         busy_o
);
  localparam int FW = $clog2(W + 1);
  localparam int IW = $clog2(INQ_DEPTH + 1);
  localparam int RW = $clog2(RES_DEPTH + 1);

  typedef struct packed {
    logic [W-1:0] m;
    logic [W-1:0] n;
  } pair_w_t;

  logic [FW-1:0] f;
  logic          f_first, f_last;
  logic          tag_run, tag_cap;
  pair_w_t       in_pair, head_pair;
  logic          in_full, in_empty, res_empty;
  logic [RW-1:0] res_count;
  logic [RW:0]   occupancy;
  logic          credit_ok, issue, res_push, res_pop;
  logic [IW-1:0] unused_in_count;
  logic          unused_res_full;

  assign f_first = (f == '0);
  assign f_last  = (f == FW'(W));

  // Results already queued plus those still travelling through the adder must
  // fit, so the result queue can never be pushed while full.
  assign occupancy = {1'b0, res_count} + (RW+1)'(tag_run) + (RW+1)'(tag_cap);
  assign credit_ok = (occupancy < (RW+1)'(RES_DEPTH));
  assign issue     = f_last & ~in_empty & credit_ok;
  assign res_push  = f_first & tag_cap;
  assign res_pop   = res_valid_o & res_ready_i;

  assign in_pair     = '{m: in_m_i, n: in_n_i};
  assign in_ready_o  = ~in_full;
  assign res_valid_o = ~res_empty;
  assign busy_o      = ~in_empty | tag_run | tag_cap | res_valid_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      f       <= FW'(PHASE0);
      tag_run <= 1'b0;
      tag_cap <= 1'b0;
      add_m_o <= '0;
      add_n_o <= '0;
    end else begin
      f <= f_last ? '0 : f + FW'(1);
      if (f_last) begin
        // The adder publishes the finishing frame's sum on this same edge.
        tag_cap <= tag_run;
        tag_run <= issue;
        if (issue) begin
          add_m_o <= head_pair.m;
          add_n_o <= head_pair.n;
        end
      end else if (f_first) begin
        tag_cap <= 1'b0;
      end
    end
  end

  sync_fifo #(.DEPTH(INQ_DEPTH), .T(pair_w_t)) u_in_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (in_valid_i & in_ready_o),
    .pop_i   (issue),
    .data_i  (in_pair),
    .data_o  (head_pair),
    .full_o  (in_full),
    .empty_o (in_empty),
    .count_o (unused_in_count)
  );

  sync_fifo #(.DEPTH(RES_DEPTH), .T(logic [W:0])) u_res_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (res_push),
    .pop_i   (res_pop),
    .data_i  (add_sum_i),
    .data_o  (res_sum_o),
    .full_o  (unused_res_full),
    .empty_o (res_empty),
    .count_o (res_count)
  );
endmodule

// File: tb/tb_adder_operand_feeder.sv
// Directed + random bench for adder_operand_feeder with a behavioural adder and
// an in-order scoreboard of expected sums.
module tb_adder_operand_feeder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_m = '0, in_n = '0;
  logic         in_ready, res_valid, busy, res_ready;
  logic [W-1:0] add_m, add_n;
  logic [W:0]   add_sum, res_sum;
  logic         rdy_fixed = 1'b0, rand_rdy = 1'b0, rnd_bit = 1'b0;

  int         n_chk = 0, n_fail = 0, n_pop = 0, cyc = 0, fc = 0;
  logic [W:0] exp_q[$];
  int         pop_cyc[$];

  always #5 clk = ~clk;

  adder_operand_feeder #(.W(W), .INQ_DEPTH(2), .RES_DEPTH(4), .PHASE0(0)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_m_i      (in_m),
    .in_n_i      (in_n),
    .add_m_o     (add_m),
    .add_n_o     (add_n),
    .add_sum_i   (add_sum),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_sum_o   (res_sum),
    .busy_o      (busy)
  );

  // Adder stand-in: publishes the frame's operand sum on the edge ending bit W.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc      <= 0;
      add_sum <= '0;
      cyc     <= 0;
    end else begin
      cyc <= cyc + 1;
      if (fc == W) begin
        fc      <= 0;
        add_sum <= {1'b0, add_m} + {1'b0, add_n};
      end else begin
        fc <= fc + 1;
      end
    end
  end

  always begin
    @(posedge clk);
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end
  assign res_ready = rand_rdy ? rnd_bit : rdy_fixed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expectation on accept, comparison on every result handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back({1'b0, in_m} + {1'b0, in_n});
      if (res_valid && res_ready) begin
        n_chk++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL sb_empty: observed result %0h, expected none", res_sum);
        end
        if (exp_q.size() > 0) check("res_sum", 32'(res_sum), 32'(exp_q.pop_front()));
        pop_cyc.push_back(cyc);
        n_pop++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] m, input logic [W-1:0] n);
    int   t = 0;
    logic ok;
    in_valid = 1'b1; in_m = m; in_n = n;
    do begin
      ok = in_ready;
      step(1);
      t++;
    end while (!ok && t < 400);
    in_valid = 1'b0;
    check("push_accepted", 32'(ok), 1);
  endtask

  task automatic drain(input int limit);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < limit) begin
      step(1);
      t++;
    end
    check("drain_busy", 32'(busy), 0);
    check("drain_sb", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_add_m"},     32'(add_m), 0);
    check({tag, "_add_n"},     32'(add_n), 0);
    check({tag, "_res_sum"},   32'(res_sum), 0);
    check({tag, "_res_valid"}, 32'(res_valid), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_in_ready"},  32'(in_ready), 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, hits, t;

    // Reset values
    step(2);
    check_reset_outputs("reset");

    // Single add: accepted in cycle 0, result visible in cycle 2W+3
    rst_n = 1'b1;
    push(8'hFF, 8'h01);
    t = 0;
    while (!res_valid && t < 100) begin step(1); t++; end
    check("single_latency", cyc, 2*W + 3);
    check("single_sum", 32'(res_sum), 32'h100);
    check("single_busy", 32'(busy), 1);
    rdy_fixed = 1'b1;
    step(2);
    check("single_popped", 32'(res_valid), 0);

    // Streaming: one result per frame
    pop_cyc.delete();
    push(8'h00, 8'h00);
    push(8'hFF, 8'hFF);
    push(8'hAA, 8'h55);
    push(8'h80, 8'h80);
    push(8'h01, 8'hFE);
    push(8'h7F, 8'h01);
    drain(300);
    check("stream_count", pop_cyc.size(), 6);
    for (int i = 1; i < pop_cyc.size(); i++)
      check("stream_gap", pop_cyc[i] - pop_cyc[i-1], W + 1);

    // Backpressure: 4 results held, 2 queued, input stalls
    rdy_fixed = 1'b0;
    base = n_pop;
    for (int i = 0; i < 6; i++) push(W'($urandom), W'($urandom));
    step(50);
    check("bp_in_ready", 32'(in_ready), 0);
    check("bp_res_valid", 32'(res_valid), 1);
    check("bp_busy", 32'(busy), 1);
    check("bp_head", 32'(res_sum), 32'(exp_q[0]));
    step(5);
    check("bp_head_stable", 32'(res_sum), 32'(exp_q[0]));
    check("bp_no_pop", n_pop - base, 0);
    pop_cyc.delete();
    rdy_fixed = 1'b1;
    push(8'hC3, 8'h3C);
    push(8'hFE, 8'hFF);
    drain(400);
    check("bp_total", n_pop - base, 8);
    for (int i = 1; i < 4; i++)
      check("bp_held_gap", pop_cyc[i] - pop_cyc[i-1], 1);

    // Reset mid-frame with two pairs in flight
    rdy_fixed = 1'b0;
    push(8'h12, 8'h34);
    push(8'h56, 8'h78);
    step(12);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step(2);
    exp_q.delete();
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (res_valid) hits++;
    end
    check("midrst_no_pulse", hits, 0);
    check("midrst_idle", 32'(busy), 0);

    // Random traffic with random consumer stalls
    rand_rdy = 1'b1;
    base = n_pop;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) step(1);
      push(W'($urandom), W'($urandom));
    end
    drain(20000);
    check("rand_total", n_pop - base, 1000);
    rand_rdy = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
